// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (shift-add-3), one input bit per clock.
// Accepts a word only when idle; words offered while converting are dropped.
module fib_bcd_converter #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      in_value,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic                  ovf,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic {S_IDLE, S_CONVERT} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_shift;
   logic [BW-1:0]    r_work;
   logic             r_sticky;
   logic [BW-1:0]    r_bcd;
   logic             r_bcd_valid;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic [BW-1:0]    w_adj;
   logic [BW-1:0]    w_work_next;
   logic             w_carry_out;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      busy         = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = !reset;
            w_accept = in_valid && !reset;
            if (w_accept) w_next_state = S_CONVERT;
         end
         S_CONVERT: begin
            busy   = 1'b1;
            w_last = (r_count == CW'(WIDTH - 1));
            if (w_last) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Add-3 correction on every digit >= 5, applied before the shift.
   always_comb begin
      w_adj = r_work;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
      end
   end

   assign w_work_next = {w_adj[BW-2:0], r_shift[WIDTH-1]};
   assign w_carry_out = w_adj[BW-1];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count     <= '0;
         r_shift     <= '0;
         r_work      <= '0;
         r_sticky    <= 1'b0;
         r_bcd       <= '0;
         r_bcd_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         if (w_accept) begin
            r_shift  <= in_value;
            r_work   <= '0;
            r_sticky <= 1'b0;
            r_count  <= '0;
         end else if (r_state == S_CONVERT) begin
            r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
            r_work   <= w_work_next;
            r_sticky <= r_sticky | w_carry_out;
            r_count  <= r_count + CW'(1);
            if (w_last) begin
               r_bcd       <= w_work_next;
               r_ovf       <= r_sticky | w_carry_out;
               r_bcd_valid <= 1'b1;
            end
         end
      end
   end

   assign bcd       = r_bcd;
   assign bcd_valid = r_bcd_valid;
   assign ovf       = r_ovf;

endmodule
